// File: rtl/kart_physics.sv
// ---------------------------------------------------------------------------
// kart_physics
//   Motion engine for one player. On each frame tick it applies the player's
//   steering and throttle to heading and speed. It then projects a candidate
//   position, looks the candidate up in the terrain ROM, and either commits
//   the move or blocks it. One instance exists per player.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   frame_tick   one-cycle pulse per video frame; starts an update when idle
//   op_code      0/7 idle, 1 fwd, 2 brake/rev, 3 left, 4 right, 5 fwd+left,
//                6 fwd+right
//   boost        raises the forward speed cap to BOOST_SPEED
//   map_addr     terrain ROM address (y*MAP_W + x of the candidate)
//   map_idx      terrain colour index, valid MAP_RD_LAT cycles after map_addr
//   world_x/y    integer world position (pos[15:6])
//   degree       heading in degrees (head_idx*15)
//   speed        signed speed, 1/64 px per tick
//   busy         update in progress
//   update_done  one-cycle pulse when the update is committed
//
// FSM
//   state  | meaning
//   IDLE   | waiting for frame_tick; op_code/boost latched on the tick
//   CTRL   | heading and speed updated from the latched operation
//   MOVE   | candidate position formed, bounds checked, ROM address issued
//   REQ    | first ROM latency cycle; out-of-bounds goes straight to COMMIT
//   WAIT   | remaining ROM latency cycles
//   COMMIT | terrain sampled; position committed or move blocked
// ---------------------------------------------------------------------------
module kart_physics #(
    parameter logic [9:0] START_X     = 10'd15,
    parameter logic [9:0] START_Y     = 10'd125,
    parameter logic [4:0] START_HEAD  = 5'd0,
    parameter logic [9:0] MAP_W       = 10'd320,
    parameter logic [9:0] MAP_H       = 10'd240,
    parameter logic [7:0] ACCEL       = 8'd4,
    parameter logic [7:0] FRICTION    = 8'd2,
    parameter logic [7:0] MAX_SPEED   = 8'd96,
    parameter logic [7:0] BOOST_SPEED = 8'd127,
    parameter logic [3:0] GRASS_IDX   = 4'd1,
    parameter logic [3:0] WALL_IDX    = 4'd5,
    parameter int         MAP_RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [2:0]  op_code,
    input  logic        boost,
    output logic [16:0] map_addr,
    input  logic [3:0]  map_idx,
    output logic [9:0]  world_x,
    output logic [9:0]  world_y,
    output logic [8:0]  degree,
    output logic [7:0]  speed,
    output logic        busy,
    output logic        update_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CTRL   = 3'd1;
    localparam logic [2:0] S_MOVE   = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    localparam int WAIT_W = 4;

    logic [2:0]        state;
    logic [15:0]       pos_x;
    logic [15:0]       pos_y;
    logic [4:0]        head_idx;
    logic signed [7:0] spd;
    logic              on_grass;
    logic [2:0]        op_q;
    logic              boost_q;
    logic [15:0]       cand_x;
    logic [15:0]       cand_y;
    logic              oob;
    logic [WAIT_W-1:0] wait_cnt;

    // Q1.7 cosine, index in 15 degree steps; 128 needs the ninth bit.
    function automatic logic signed [8:0] cos_q7(input logic [4:0] idx);
        case (idx)
            5'd0:    cos_q7 =  9'sd128;
            5'd1:    cos_q7 =  9'sd124;
            5'd2:    cos_q7 =  9'sd111;
            5'd3:    cos_q7 =  9'sd91;
            5'd4:    cos_q7 =  9'sd64;
            5'd5:    cos_q7 =  9'sd33;
            5'd6:    cos_q7 =  9'sd0;
            5'd7:    cos_q7 = -9'sd33;
            5'd8:    cos_q7 = -9'sd64;
            5'd9:    cos_q7 = -9'sd91;
            5'd10:   cos_q7 = -9'sd111;
            5'd11:   cos_q7 = -9'sd124;
            5'd12:   cos_q7 = -9'sd128;
            5'd13:   cos_q7 = -9'sd124;
            5'd14:   cos_q7 = -9'sd111;
            5'd15:   cos_q7 = -9'sd91;
            5'd16:   cos_q7 = -9'sd64;
            5'd17:   cos_q7 = -9'sd33;
            5'd18:   cos_q7 =  9'sd0;
            5'd19:   cos_q7 =  9'sd33;
            5'd20:   cos_q7 =  9'sd64;
            5'd21:   cos_q7 =  9'sd91;
            5'd22:   cos_q7 =  9'sd111;
            5'd23:   cos_q7 =  9'sd124;
            default: cos_q7 =  9'sd0;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Operation decode
    // ---------------------------------------------------------------------
    logic is_fwd;
    logic is_brk;
    logic is_left;
    logic is_right;

    assign is_fwd   = (op_q == 3'd1) || (op_q == 3'd5) || (op_q == 3'd6);
    assign is_brk   = (op_q == 3'd2);
    assign is_left  = (op_q == 3'd3) || (op_q == 3'd5);
    assign is_right = (op_q == 3'd4) || (op_q == 3'd6);

    // ---------------------------------------------------------------------
    // Steering and throttle (used in CTRL)
    // ---------------------------------------------------------------------
    logic [4:0]        head_nxt;
    logic [7:0]        cap8;
    logic signed [9:0] spd_w;
    logic signed [9:0] cap_w;
    logic signed [9:0] acc_w;
    logic signed [9:0] brk_w;
    logic signed [9:0] rev_min_w;
    logic signed [9:0] fric_w;
    logic signed [7:0] spd_nxt;

    assign cap8      = boost_q ? BOOST_SPEED : MAX_SPEED;
    assign cap_w     = on_grass ? $signed({3'b000, cap8[7:1]}) : $signed({2'b00, cap8});
    assign spd_w     = {{2{spd[7]}}, spd};
    assign acc_w     = spd_w + $signed({2'b00, ACCEL});
    assign brk_w     = spd_w - $signed({2'b00, ACCEL});
    assign rev_min_w = -$signed({3'b000, MAX_SPEED[7:1]});
    assign fric_w    = $signed({2'b00, FRICTION});

    always_comb begin
        head_nxt = head_idx;
        if (is_left) begin
            head_nxt = (head_idx == 5'd0) ? 5'd23 : head_idx - 5'd1;
        end else if (is_right) begin
            head_nxt = (head_idx == 5'd23) ? 5'd0 : head_idx + 5'd1;
        end
    end

    // acc_w > cap_w also covers the case where speed already exceeds the
    // cap (e.g. after leaving boost or entering grass): it snaps to the cap.
    always_comb begin
        spd_nxt = spd;
        if (is_fwd) begin
            spd_nxt = (acc_w > cap_w) ? cap_w[7:0] : acc_w[7:0];
        end else if (is_brk) begin
            spd_nxt = (brk_w < rev_min_w) ? rev_min_w[7:0] : brk_w[7:0];
        end else if (spd_w > fric_w) begin
            spd_nxt = spd - FRICTION;
        end else if (spd_w < -fric_w) begin
            spd_nxt = spd + FRICTION;
        end else begin
            spd_nxt = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Candidate position (used in MOVE)
    // ---------------------------------------------------------------------
    logic [4:0]         sin_idx;
    logic signed [8:0]  cos_v;
    logic signed [8:0]  sin_v;
    logic signed [16:0] prod_x;
    logic signed [16:0] prod_y;
    logic signed [16:0] dx;
    logic signed [16:0] dy;
    logic signed [16:0] cand_x_w;
    logic signed [16:0] cand_y_w;
    logic               oob_w;
    logic [16:0]        addr_w;

    // sin(a) = cos(a - 90 deg); 90 deg is six table steps.
    assign sin_idx  = (head_idx >= 5'd6) ? head_idx - 5'd6 : head_idx + 5'd18;
    assign cos_v    = cos_q7(head_idx);
    assign sin_v    = cos_q7(sin_idx);
    assign prod_x   = $signed({{9{spd[7]}}, spd}) * $signed({{8{cos_v[8]}}, cos_v});
    assign prod_y   = $signed({{9{spd[7]}}, spd}) * $signed({{8{sin_v[8]}}, sin_v});
    assign dx       = prod_x >>> 7;
    assign dy       = prod_y >>> 7;
    assign cand_x_w = $signed({1'b0, pos_x}) + dx;
    assign cand_y_w = $signed({1'b0, pos_y}) + dy;

    // Bit 16 set means the candidate went negative.
    assign oob_w = cand_x_w[16] || cand_y_w[16] ||
                   (cand_x_w[15:6] >= MAP_W) || (cand_y_w[15:6] >= MAP_H);

    assign addr_w = ({7'd0, cand_y_w[15:6]} * {7'd0, MAP_W}) + {7'd0, cand_x_w[15:6]};

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    // The ROM address is registered together with the candidate at the end
    // of MOVE, so REQ already counts as the first ROM latency cycle and the
    // data is valid exactly when COMMIT samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pos_x       <= {START_X, 6'b0};
            pos_y       <= {START_Y, 6'b0};
            head_idx    <= START_HEAD;
            spd         <= '0;
            on_grass    <= 1'b0;
            op_q        <= '0;
            boost_q     <= 1'b0;
            cand_x      <= '0;
            cand_y      <= '0;
            oob         <= 1'b0;
            wait_cnt    <= '0;
            map_addr    <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            update_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        op_q    <= op_code;
                        boost_q <= boost;
                        busy    <= 1'b1;
                        state   <= S_CTRL;
                    end
                end
                S_CTRL: begin
                    head_idx <= head_nxt;
                    spd      <= spd_nxt;
                    state    <= S_MOVE;
                end
                S_MOVE: begin
                    cand_x <= cand_x_w[15:0];
                    cand_y <= cand_y_w[15:0];
                    oob    <= oob_w;
                    if (!oob_w) begin
                        map_addr <= addr_w;
                    end
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (oob || (MAP_RD_LAT <= 1)) begin
                        state <= S_COMMIT;
                    end else begin
                        wait_cnt <= WAIT_W'(MAP_RD_LAT - 2);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (oob || (map_idx == WALL_IDX)) begin
                        spd <= '0;
                    end else begin
                        pos_x    <= cand_x;
                        pos_y    <= cand_y;
                        on_grass <= (map_idx == GRASS_IDX);
                    end
                    update_done <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign world_x = pos_x[15:6];
    assign world_y = pos_y[15:6];
    assign speed   = spd;
    // head_idx*15 as (head_idx << 4) - head_idx.
    assign degree  = ({4'd0, head_idx} << 4) - {4'd0, head_idx};

endmodule
